// File: rtl/riscv_pkg.sv
// Shared RV32I definitions for the branch/PC stage.
//   - funct3 encodings of the supported conditional branches
//   - fault_cause encodings reported by branch_pc_unit
//   - RUN/TRAP state type of the PC-stage state machine
//   - default reset and trap-vector addresses
package riscv_pkg;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;
    localparam logic [2:0] F3_BLT = 3'b100;
    localparam logic [2:0] F3_BGE = 3'b101;

    typedef enum logic [1:0] {
        CAUSE_NONE       = 2'b00,
        CAUSE_MISALIGNED = 2'b01,
        CAUSE_ILLEGAL    = 2'b10
    } cause_t;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_TRAP = 1'b1
    } state_t;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_TRAP_PC  = 32'h0000_0100;

endpackage

// File: rtl/branch_cond.sv
// Conditional-branch evaluator.
//   funct3    in  3  branch condition select
//   Zero      in  1  ALU zero flag (A-B == 0)
//   Sign_Flag in  1  ALU result bit 31 (A-B < 0, overflow ignored)
//   taken     out 1  condition true for a supported encoding
//   illegal   out 1  funct3 is not BEQ/BNE/BLT/BGE
// Unsigned branches are rejected because the ALU provides no carry flag.
module branch_cond
    import riscv_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       Zero,
    input  logic       Sign_Flag,
    output logic       taken,
    output logic       illegal
);

    // NOTE: every output gets a default before the case so no path leaves
    // it unassigned; a missing default in always_comb infers a latch.
    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        case (funct3)
            F3_BEQ:  taken = Zero;
            F3_BNE:  taken = ~Zero;
            F3_BLT:  taken = Sign_Flag;
            F3_BGE:  taken = ~Sign_Flag;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_pc_unit.sv
// Program-counter and branch-resolution stage.
//   clk, rst          rising-edge clock, synchronous active-high reset
//   stall             freeze PC, counter, state machine and trap
//   branch/jump/jalr  control-transfer kind (priority jalr > jump > branch)
//   funct3            branch condition select
//   Zero, Sign_Flag   ALU flags for branch resolution
//   ALUResult         JALR target (rs1+imm)
//   ImmExt            sign-extended B/J immediate
//   PC                registered current PC
//   PCPlus4           link value, combinational
//   PCTarget          resolved target, combinational
//   PCSrc             transfer taken this cycle, combinational
//   trap              one-cycle registered pulse when a fault is taken
//   fault             sticky fault flag, cleared only by rst
//   fault_cause       01 misaligned target, 10 illegal funct3, 00 none
//   instret           retired-instruction counter
module branch_pc_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [31:0] TRAP_PC  = DEFAULT_TRAP_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch,
    input  logic        jump,
    input  logic        jalr,
    input  logic [2:0]  funct3,
    input  logic        Zero,
    input  logic        Sign_Flag,
    input  logic [31:0] ALUResult,
    input  logic [31:0] ImmExt,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic [31:0] PCTarget,
    output logic        PCSrc,
    output logic        trap,
    output logic        fault,
    output logic [1:0]  fault_cause,
    output logic [31:0] instret
);

    logic [31:0] pc_r;
    logic [31:0] pc_n;
    state_t      state_r;
    state_t      state_n;
    logic        fault_r;
    cause_t      cause_r;
    logic [31:0] instret_r;

    logic        cond_taken;
    logic        cond_illegal;
    logic        is_branch;
    logic        illegal_now;
    logic        misaligned_now;
    logic        fault_take;
    cause_t      cause_now;

    branch_cond u_cond (
        .funct3    (funct3),
        .Zero      (Zero),
        .Sign_Flag (Sign_Flag),
        .taken     (cond_taken),
        .illegal   (cond_illegal)
    );

    // A branch flag raised alongside jump/jalr is ignored entirely, so it
    // can neither redirect nor raise an illegal-funct3 fault.
    assign is_branch = branch & ~jump & ~jalr;

    assign PCPlus4  = pc_r + 32'd4;
    assign PCTarget = jalr ? {ALUResult[31:1], 1'b0} : pc_r + ImmExt;
    assign PCSrc    = jalr | jump | (is_branch & cond_taken & ~cond_illegal);

    assign illegal_now    = is_branch & cond_illegal;
    assign misaligned_now = PCSrc & PCTarget[1];
    assign cause_now      = illegal_now ? CAUSE_ILLEGAL : CAUSE_MISALIGNED;

    // Faults are taken only from RUN; the TRAP cycle always drains back to
    // RUN, and nothing is recorded while the pipeline is stalled.
    assign fault_take = ~stall & (state_r == ST_RUN) & (illegal_now | misaligned_now);

    always_comb begin
        state_n = state_r;
        pc_n    = pc_r;
        if (!stall) begin
            if (fault_take) begin
                state_n = ST_TRAP;
                pc_n    = TRAP_PC;
            end else begin
                state_n = ST_RUN;
                pc_n    = PCSrc ? PCTarget : PCPlus4;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r      <= RESET_PC;
            state_r   <= ST_RUN;
            fault_r   <= 1'b0;
            cause_r   <= CAUSE_NONE;
            instret_r <= '0;
        end else if (!stall) begin
            pc_r    <= pc_n;
            state_r <= state_n;
            if (fault_take) begin
                fault_r <= 1'b1;
                cause_r <= cause_now;
            end else begin
                instret_r <= instret_r + 32'd1;
            end
        end
    end

    assign PC          = pc_r;
    assign trap        = (state_r == ST_TRAP);
    assign fault       = fault_r;
    assign fault_cause = cause_r;
    assign instret     = instret_r;

endmodule

// File: tb/tb_branch_pc_unit.sv
// Self-checking bench for branch_pc_unit: directed scenarios followed by
// randomized traffic. The driver advances a behavioural model of the PC
// stage and queues the expected responses; an independent monitor pops and
// compares them against the DUT.
module tb_branch_pc_unit;

    localparam int K_NONE = 0;
    localparam int K_BR   = 1;
    localparam int K_JAL  = 2;
    localparam int K_JALR = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        branch = 1'b0;
    logic        jump = 1'b0;
    logic        jalr = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic        Zero = 1'b0;
    logic        Sign_Flag = 1'b0;
    logic [31:0] ALUResult = '0;
    logic [31:0] ImmExt = '0;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic [31:0] PCTarget;
    logic        PCSrc;
    logic        trap;
    logic        fault;
    logic [1:0]  fault_cause;
    logic [31:0] instret;

    branch_pc_unit dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .branch      (branch),
        .jump        (jump),
        .jalr        (jalr),
        .funct3      (funct3),
        .Zero        (Zero),
        .Sign_Flag   (Sign_Flag),
        .ALUResult   (ALUResult),
        .ImmExt      (ImmExt),
        .PC          (PC),
        .PCPlus4     (PCPlus4),
        .PCTarget    (PCTarget),
        .PCSrc       (PCSrc),
        .trap        (trap),
        .fault       (fault),
        .fault_cause (fault_cause),
        .instret     (instret)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] plus4;
        logic [31:0] target;
        logic        src;
        bit          known;
    } comb_t;

    typedef struct {
        logic [31:0] pc;
        logic        trap;
        logic        fault;
        logic [1:0]  cause;
        logic [31:0] instret;
    } regs_t;

    comb_t comb_q[$];
    regs_t regs_q[$];

    int n_compared = 0;
    int n_mismatched = 0;

    // Reference state of the PC stage.
    bit          m_known = 1'b0;
    logic [31:0] m_pc = '0;
    bit          m_trap = 1'b0;
    bit          m_fault = 1'b0;
    logic [1:0]  m_cause = 2'b00;
    logic [31:0] m_instret = '0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Applies one cycle of inputs at the falling edge and advances the model
    // to the state expected after the next rising edge.
    task automatic drive(input bit r, input bit s, input int kind, input logic [2:0] f3,
                         input bit z, input bit sg, input logic [31:0] alu, input logic [31:0] imm);
        logic [31:0] tgt;
        bit          legal;
        bit          cond;
        bit          src;
        logic [1:0]  cause;
        comb_t       c;
        regs_t       g;
        @(negedge clk);
        rst = r; stall = s;
        branch = (kind == K_BR); jump = (kind == K_JAL); jalr = (kind == K_JALR);
        funct3 = f3; Zero = z; Sign_Flag = sg; ALUResult = alu; ImmExt = imm;

        tgt   = (kind == K_JALR) ? (alu & 32'hFFFF_FFFE) : m_pc + imm;
        legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd4) || (f3 == 3'd5);
        case (f3)
            3'd0:    cond = z;
            3'd1:    cond = !z;
            3'd4:    cond = sg;
            3'd5:    cond = !sg;
            default: cond = 1'b0;
        endcase
        src = (kind == K_JAL) || (kind == K_JALR) || (kind == K_BR && legal && cond);
        if (kind == K_BR && !legal)  cause = 2'b10;
        else if (src && tgt[1])      cause = 2'b01;
        else                         cause = 2'b00;

        c.plus4 = m_pc + 32'd4; c.target = tgt; c.src = src; c.known = m_known;
        comb_q.push_back(c);

        if (r) begin
            m_known = 1'b1; m_pc = 32'h0; m_trap = 1'b0; m_fault = 1'b0;
            m_cause = 2'b00; m_instret = 32'h0;
        end else if (!s) begin
            if (cause != 2'b00 && !m_trap) begin
                m_pc = 32'h100; m_trap = 1'b1; m_fault = 1'b1; m_cause = cause;
            end else begin
                m_pc = src ? tgt : m_pc + 32'd4;
                m_trap = 1'b0;
                m_instret = m_instret + 32'd1;
            end
        end
        g.pc = m_pc; g.trap = m_trap; g.fault = m_fault; g.cause = m_cause; g.instret = m_instret;
        regs_q.push_back(g);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, K_NONE, 3'd0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    // Monitor: combinational outputs are sampled after the inputs settle,
    // registered outputs shortly after the rising edge.
    initial begin
        comb_t c;
        regs_t g;
        forever begin
            @(negedge clk);
            #2;
            if (comb_q.size() > 0) begin
                c = comb_q.pop_front();
                if (c.known) begin
                    check("PCPlus4", PCPlus4, c.plus4);
                    check("PCTarget", PCTarget, c.target);
                    check("PCSrc", {31'b0, PCSrc}, {31'b0, c.src});
                end
            end
            @(posedge clk);
            #1;
            if (regs_q.size() > 0) begin
                g = regs_q.pop_front();
                check("PC", PC, g.pc);
                check("trap", {31'b0, trap}, {31'b0, g.trap});
                check("fault", {31'b0, fault}, {31'b0, g.fault});
                check("fault_cause", {30'b0, fault_cause}, {30'b0, g.cause});
                check("instret", instret, g.instret);
            end
        end
    end

    initial begin
        int          kind;
        logic [31:0] imm;
        logic [2:0]  f3;

        // Reset, then free-running to 0x10; BEQ taken to 0x30.
        drive(1'b1, 1'b0, K_NONE, 3'd0, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (4) idle();
        drive(1'b0, 1'b0, K_BR, 3'b000, 1'b1, 1'b0, 32'h0, 32'h20);
        // BEQ not taken at 0x10 -> 0x14.
        drive(1'b1, 1'b0, K_NONE, 3'd0, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (4) idle();
        drive(1'b0, 1'b0, K_BR, 3'b000, 1'b0, 1'b0, 32'h0, 32'h20);
        // JAL to 0x40, BLT taken back to 0x30, JAL to 0x40, BGE not taken.
        drive(1'b0, 1'b0, K_JAL, 3'd0, 1'b0, 1'b0, 32'h0, 32'h2C);
        drive(1'b0, 1'b0, K_BR, 3'b100, 1'b0, 1'b1, 32'h0, 32'hFFFF_FFF0);
        drive(1'b0, 1'b0, K_JAL, 3'd0, 1'b0, 1'b0, 32'h0, 32'h10);
        drive(1'b0, 1'b0, K_BR, 3'b101, 1'b0, 1'b1, 32'h0, 32'hFFFF_FFF0);
        // Misaligned JALR, one TRAP cycle, then illegal funct3.
        drive(1'b0, 1'b0, K_JALR, 3'd0, 1'b0, 1'b0, 32'h0000_1003, 32'h0);
        idle();
        drive(1'b0, 1'b0, K_BR, 3'b110, 1'b1, 1'b0, 32'h0, 32'h8);
        // Stretch the trap pulse with two stalled cycles, then reset.
        drive(1'b0, 1'b1, K_JALR, 3'd0, 1'b0, 1'b0, 32'h0000_0202, 32'h0);
        drive(1'b0, 1'b1, K_BR, 3'b111, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b1, K_NONE, 3'd0, 1'b0, 1'b0, 32'h0, 32'h0);
        idle();

        // Counter wrap-around from a forced all-ones value.
        @(posedge clk);
        #3;
        force dut.instret_r = 32'hFFFF_FFFF;
        #1;
        release dut.instret_r;
        m_instret = 32'hFFFF_FFFF;
        idle();
        idle();

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            kind = m_trap ? K_NONE : int'($urandom_range(0, 3));
            f3 = ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'($urandom_range(0, 1) + 4 * $urandom_range(0, 1));
            imm = {$urandom() & 32'hFFFF_FFFC};
            if ($urandom_range(0, 7) == 0) imm[1] = 1'b1;
            drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 7) == 0), kind, f3,
                  1'($urandom), 1'($urandom), $urandom(), imm);
        end
        idle();

        // Drain the scoreboard with a bounded wait.
        for (int t = 0; t < 20 && (comb_q.size() > 0 || regs_q.size() > 0); t++) @(negedge clk);
        repeat (2) @(negedge clk);
        if (comb_q.size() > 0 || regs_q.size() > 0) begin
            n_compared++;
            n_mismatched++;
            $display("FAIL drain: %0d comb / %0d reg expectations left, expected 0", comb_q.size(), regs_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
